intersection_sched: RTL and testbench
=====================================

INTERSECTION_SCHED -- requirements
Module: intersection_sched

Interface
REQ-001 SHALL have parameter TW, default 16, meaning the width of all timing inputs and the internal phase counter.
REQ-002 SHALL have port ck, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req1 / req2, input, 1 bit each: vehicle-detect request for road 1 / road 2; level, synchronous to ck.
REQ-005 SHALL have port min_g, input, TW bits: minimum green duration, in cycles.
REQ-006 SHALL have port max_g, input, TW bits: maximum green duration under opposing demand, in cycles.
REQ-007 SHALL have port yel_t / clr_t, input, TW bits each: yellow duration / all-red clearance duration, in cycles.
REQ-008 SHALL have port g1,y1,r1,g2,y2,r2, output, 1 bit each: lamp drives, 1 = on.
REQ-009 SHALL have port phase, output, 3 bits: current state encoding, for debug.

Function
REQ-010 SHALL implement the six-state cycle G1 -> Y1 -> AR1 -> G2 -> Y2 -> AR2 -> G1 and no other transitions.
REQ-011 SHALL drive exactly one lamp per road, combinationally from the state: G1 (g1,r2), Y1 (y1,r2), AR1/AR2 (r1,r2), G2 (r1,g2), Y2 (r1,y2).
REQ-012 SHALL keep a phase counter e that is 1 in the first cycle of each state and increments by 1 per cycle, saturating at all-ones.
REQ-013 SHALL latch pend1 on req1=1 and pend2 on req2=1.
REQ-014 SHALL clear pendN in the cycle that state GN is entered, and SHALL let a simultaneous reqN=1 win, keeping pendN set.
REQ-015 SHALL load min_g, max_g, yel_t and clr_t into internal registers on entry to each state; mid-state input changes SHALL have no effect until the next entry.
REQ-016 SHALL treat any duration of 0 as 1.
REQ-017 SHALL treat max_g < min_g as max_g = min_g.
REQ-018 SHALL leave GN only if the opposing pend is set and e >= min_g, and in addition either reqN = 0 or e >= max_g.
REQ-019 SHALL rest in GN indefinitely while there is no opposing pend.
REQ-020 SHALL leave YN when e == yel_t and ARN when e == clr_t.
REQ-021 SHALL resolve simultaneous pend1 and pend2 by the fixed cycle order alone, with no priority logic.
REQ-022 SHALL make the state change on the edge at which the exit condition is true; the new lamp pattern SHALL be visible in the following cycle.

Reset
REQ-023 SHALL, while rst_n = 0, force state AR2, e = 1, pend1 = pend2 = 0, and outputs r1 = r2 = 1 with all other lamps 0, independent of ck.
REQ-024 SHALL, after rst_n rises, serve AR2 for clr_t cycles and then enter G1.
REQ-025 SHALL, if reset is asserted mid-phase, discard all timing and pending requests.

Structure
REQ-026 SHALL take the state enumeration and its encoding (G1=0, Y1=1, AR1=2, G2=3, Y2=4, AR2=5) from shared package traffic_pkg, together with the TW default.
REQ-027 SHALL place the phase counter (restart, saturate, compare against a loaded limit) in one sub-module, phase_timer.
REQ-028 SHALL instantiate phase_timer once.

Verification
REQ-029 SHALL be verified with: rst_n low, then high, clr_t=2 -> r1,r2 for 2 cycles, then G1 (g1,r2).
REQ-030 SHALL be verified with: min_g=4, max_g=10, yel_t=3, clr_t=2, req2 pulsed in cycle 1 of G1, req1=0 -> G1 held 4 cycles, Y1 3 cycles, AR1 2 cycles, then G2.
REQ-031 SHALL be verified with: same settings, req1 held 1, req2 pulsed -> G1 lasts exactly 10 cycles (max_g).
REQ-032 SHALL be verified with: no requests for 100 cycles after G1 entry -> G1 held throughout, no yellow.
REQ-033 SHALL be verified with: yel_t=0, clr_t=0 -> Y1 and AR1 each last 1 cycle; min_g changed mid-G1 -> current G1 unaffected.
REQ-034 SHALL be verified with: rst_n asserted during Y1 -> r1,r2 immediately, pend cleared, restart from AR2.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection scheduler: phase encoding,
// default timing width and the fixed phase succession.
package traffic_pkg;

   localparam int TW_DEFAULT = 16;

   localparam logic [2:0] ST_G1  = 3'd0;
   localparam logic [2:0] ST_Y1  = 3'd1;
   localparam logic [2:0] ST_AR1 = 3'd2;
   localparam logic [2:0] ST_G2  = 3'd3;
   localparam logic [2:0] ST_Y2  = 3'd4;
   localparam logic [2:0] ST_AR2 = 3'd5;

   // Unused codes fall back to all-red so the cycle restarts safely.
   function automatic logic [2:0] next_phase(input logic [2:0] ph);
      case (ph)
         ST_G1:   return ST_Y1;
         ST_Y1:   return ST_AR1;
         ST_AR1:  return ST_G2;
         ST_G2:   return ST_Y2;
         ST_Y2:   return ST_AR2;
         ST_AR2:  return ST_G1;
         default: return ST_AR2;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Elapsed-cycle counter for the current phase. It holds two limits that are
// captured in the first cycle of each phase and compares the count against them.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int TW = TW_DEFAULT
) (
   input  logic          ck,
   input  logic          rst_n,
   input  logic          restart,
   input  logic [TW-1:0] lim_a_in,
   input  logic [TW-1:0] lim_b_in,
   output logic          at_a,
   output logic          reach_a,
   output logic          reach_b
);

   localparam logic [TW-1:0] ONE = TW'(1);

   logic [TW-1:0] e_q, e_d;
   logic [TW-1:0] lim_a_q, lim_a_d;
   logic [TW-1:0] lim_b_q, lim_b_d;
   logic [TW-1:0] lim_a, lim_b;
   logic          first;

   // The first cycle of a phase sees the live limits; later cycles see the captured copy.
   always_comb begin
      first   = (e_q == ONE);
      lim_a   = first ? lim_a_in : lim_a_q;
      lim_b   = first ? lim_b_in : lim_b_q;
      lim_a_d = lim_a;
      lim_b_d = lim_b;
      if (restart) begin
         e_d = ONE;
      end else if (&e_q) begin
         e_d = e_q;
      end else begin
         e_d = e_q + ONE;
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         e_q     <= ONE;
         lim_a_q <= ONE;
         lim_b_q <= ONE;
      end else begin
         e_q     <= e_d;
         lim_a_q <= lim_a_d;
         lim_b_q <= lim_b_d;
      end
   end

   assign at_a    = (e_q == lim_a);
   assign reach_a = (e_q >= lim_a);
   assign reach_b = (e_q >= lim_b);

endmodule

// File: rtl/intersection_sched.sv
// Two-road traffic-light scheduler: fixed six-phase cycle with demand-driven
// green extension, latched requests and per-phase captured timing.
module intersection_sched
   import traffic_pkg::*;
#(
   parameter int TW = TW_DEFAULT
) (
   input  logic          ck,
   input  logic          rst_n,
   input  logic          req1,
   input  logic          req2,
   input  logic [TW-1:0] min_g,
   input  logic [TW-1:0] max_g,
   input  logic [TW-1:0] yel_t,
   input  logic [TW-1:0] clr_t,
   output logic          g1,
   output logic          y1,
   output logic          r1,
   output logic          g2,
   output logic          y2,
   output logic          r2,
   output logic [2:0]    phase
);

   logic [2:0]    state_q, state_d;
   logic          pend1_q, pend1_d;
   logic          pend2_q, pend2_d;
   logic [TW-1:0] min_eff, max_eff, lim_a_in;
   logic          restart, exit_now, at_a, reach_a, reach_b;

   function automatic logic [TW-1:0] nz(input logic [TW-1:0] v);
      return (v == '0) ? TW'(1) : v;
   endfunction

   // Zero durations count as one cycle; a max below min collapses onto min.
   always_comb begin
      min_eff = nz(min_g);
      max_eff = nz(max_g);
      if (max_eff < min_eff) begin
         max_eff = min_eff;
      end
      case (state_q)
         ST_G1, ST_G2: lim_a_in = min_eff;
         ST_Y1, ST_Y2: lim_a_in = nz(yel_t);
         default:      lim_a_in = nz(clr_t);
      endcase
   end

   always_comb begin
      exit_now = 1'b0;
      case (state_q)
         ST_G1:                        exit_now = pend2_q && reach_a && (!req1 || reach_b);
         ST_G2:                        exit_now = pend1_q && reach_a && (!req2 || reach_b);
         ST_Y1, ST_Y2, ST_AR1, ST_AR2: exit_now = at_a;
         default:                      exit_now = 1'b1;
      endcase
      state_d = exit_now ? next_phase(state_q) : state_q;
      restart = (state_d != state_q);
      // A request arriving on the very edge its green starts survives the clear.
      pend1_d = req1 | (pend1_q & ~((state_d == ST_G1) && (state_q != ST_G1)));
      pend2_d = req2 | (pend2_q & ~((state_d == ST_G2) && (state_q != ST_G2)));
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_AR2;
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pend1_q <= pend1_d;
         pend2_q <= pend2_d;
      end
   end

   phase_timer #(.TW(TW)) u_timer (
      .ck       (ck),
      .rst_n    (rst_n),
      .restart  (restart),
      .lim_a_in (lim_a_in),
      .lim_b_in (max_eff),
      .at_a     (at_a),
      .reach_a  (reach_a),
      .reach_b  (reach_b)
   );

   always_comb begin
      {g1, y1, r1, g2, y2, r2} = 6'b001001;
      case (state_q)
         ST_G1:   {g1, y1, r1, g2, y2, r2} = 6'b100001;
         ST_Y1:   {g1, y1, r1, g2, y2, r2} = 6'b010001;
         ST_G2:   {g1, y1, r1, g2, y2, r2} = 6'b001100;
         ST_Y2:   {g1, y1, r1, g2, y2, r2} = 6'b001010;
         default: {g1, y1, r1, g2, y2, r2} = 6'b001001;
      endcase
   end

   assign phase = state_q;

endmodule

// File: tb/tb_intersection_sched.sv
// Directed scenarios followed by randomized request traffic, all checked
// cycle by cycle against a phase/elapsed-time reference model.
module tb_intersection_sched;

   logic        ck = 1'b0;
   logic        rst_n = 1'b1;
   logic        req1 = 1'b0;
   logic        req2 = 1'b0;
   logic [15:0] min_g = 16'd4;
   logic [15:0] max_g = 16'd10;
   logic [15:0] yel_t = 16'd3;
   logic [15:0] clr_t = 16'd2;
   logic        g1, y1, r1, g2, y2, r2;
   logic [2:0]  phase;

   int compared = 0;
   int mismatched = 0;

   // Reference model: phase index in cycle order, elapsed cycles, pending demand.
   int m_ph, m_el, m_min, m_max, m_yel, m_clr;
   bit m_p1, m_p2;

   intersection_sched #(.TW(16)) dut (
      .ck    (ck),
      .rst_n (rst_n),
      .req1  (req1),
      .req2  (req2),
      .min_g (min_g),
      .max_g (max_g),
      .yel_t (yel_t),
      .clr_t (clr_t),
      .g1    (g1),
      .y1    (y1),
      .r1    (r1),
      .g2    (g2),
      .y2    (y2),
      .r2    (r2),
      .phase (phase)
   );

   always #5 ck = ~ck;

   function automatic logic [5:0] expect_lamps(input int ph);
      case (ph)
         0:       return 6'b100001;
         1:       return 6'b010001;
         3:       return 6'b001100;
         4:       return 6'b001010;
         default: return 6'b001001;
      endcase
   endfunction

   function automatic int dur(input logic [15:0] v);
      return (v == 16'd0) ? 1 : int'(v);
   endfunction

   task automatic model_reset();
      m_ph = 5;
      m_el = 1;
      m_p1 = 1'b0;
      m_p2 = 1'b0;
   endtask

   task automatic model_update();
      bit leave;
      if (m_el == 1) begin
         m_min = dur(min_g);
         m_max = dur(max_g);
         if (m_max < m_min) m_max = m_min;
         m_yel = dur(yel_t);
         m_clr = dur(clr_t);
      end
      case (m_ph)
         0:       leave = m_p2 && (m_el >= m_min) && (!req1 || (m_el >= m_max));
         3:       leave = m_p1 && (m_el >= m_min) && (!req2 || (m_el >= m_max));
         1, 4:    leave = (m_el == m_yel);
         default: leave = (m_el == m_clr);
      endcase
      m_p1 = req1 || (m_p1 && !(leave && (m_ph == 5)));
      m_p2 = req2 || (m_p2 && !(leave && (m_ph == 2)));
      if (leave) begin
         m_ph = (m_ph + 1) % 6;
         m_el = 1;
      end else if (m_el < 65535) begin
         m_el = m_el + 1;
      end
   endtask

   task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ck);
      if (rst_n) model_update();
      @(negedge ck);
      check_output("lamps", {2'b0, g1, y1, r1, g2, y2, r2}, {2'b0, expect_lamps(m_ph)});
      check_output("phase", {5'b0, phase}, 8'(m_ph));
   endtask

   task automatic hold(input int p, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         check_output(tag, {5'b0, phase}, 8'(p));
         step();
      end
   endtask

   task automatic apply_stimulus(input int p1, input int p2);
      req1 = ($urandom_range(0, 99) < p1);
      req2 = ($urandom_range(0, 99) < p2);
   endtask

   initial begin
      $display("[TB] start");
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_output("reset_lamps_async", {2'b0, g1, y1, r1, g2, y2, r2}, 8'b00001001);
      check_output("reset_phase_async", {5'b0, phase}, 8'd5);
      @(negedge ck);
      step();
      step();

      // Release: AR2 for clr_t cycles, then G1; short demand gives min green.
      rst_n = 1'b1;
      hold(5, 2, "ar2_after_reset");
      check_output("g1_lamps", {2'b0, g1, y1, r1, g2, y2, r2}, 8'b00100001);
      req2 = 1'b1;
      hold(0, 1, "g1_min");
      req2 = 1'b0;
      hold(0, 3, "g1_min");
      hold(1, 3, "y1_len");
      hold(2, 2, "ar1_len");
      check_output("g2_lamps", {2'b0, g1, y1, r1, g2, y2, r2}, 8'b00001100);
      req1 = 1'b1;
      hold(3, 1, "g2_min");
      req1 = 1'b0;
      hold(3, 3, "g2_min");
      hold(4, 3, "y2_len");
      hold(5, 2, "ar2_len");

      // Own-road demand held: green extends to max_g.
      req1 = 1'b1;
      req2 = 1'b1;
      hold(0, 1, "g1_max");
      req2 = 1'b0;
      hold(0, 9, "g1_max");
      hold(1, 3, "y1_len2");
      hold(2, 2, "ar1_len2");
      req1 = 1'b0;
      hold(3, 4, "g2_latched_pend1");
      hold(4, 3, "y2_len2");
      hold(5, 2, "ar2_len2");

      // No demand: G1 rests.
      hold(0, 100, "g1_rest");
      check_output("no_yellow", {7'b0, y1}, 8'd0);

      // Zero yellow/clearance, then a mid-green min_g change.
      yel_t = 16'd0;
      clr_t = 16'd0;
      req2 = 1'b1;
      hold(0, 1, "g1_leave");
      req2 = 1'b0;
      hold(0, 1, "g1_leave");
      hold(1, 1, "y1_zero");
      hold(2, 1, "ar1_zero");
      req1 = 1'b1;
      hold(3, 1, "g2_zero");
      req1 = 1'b0;
      hold(3, 3, "g2_zero");
      hold(4, 1, "y2_zero");
      hold(5, 1, "ar2_zero");
      req2 = 1'b1;
      hold(0, 1, "g1_minchg");
      req2 = 1'b0;
      min_g = 16'd8;
      hold(0, 3, "g1_minchg");
      hold(1, 1, "y1_zero2");
      hold(2, 1, "ar1_zero2");
      req1 = 1'b1;
      hold(3, 1, "g2_min8");
      req1 = 1'b0;
      min_g = 16'd4;
      yel_t = 16'd3;
      clr_t = 16'd2;
      hold(3, 7, "g2_min8");
      hold(4, 3, "y2_len3");
      hold(5, 2, "ar2_len3");

      // Reset during Y1 with road-1 demand pending.
      req2 = 1'b1;
      hold(0, 1, "g1_pre_rst");
      req2 = 1'b0;
      hold(0, 3, "g1_pre_rst");
      hold(1, 1, "y1_pre_rst");
      req1 = 1'b1;
      hold(1, 1, "y1_pre_rst");
      req1 = 1'b0;
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check_output("rst_midy1_lamps", {2'b0, g1, y1, r1, g2, y2, r2}, 8'b00001001);
      check_output("rst_midy1_phase", {5'b0, phase}, 8'd5);
      @(negedge ck);
      step();
      rst_n = 1'b1;
      hold(5, 2, "ar2_restart");
      req2 = 1'b1;
      hold(0, 1, "g1_restart");
      req2 = 1'b0;
      hold(0, 3, "g1_restart");
      hold(1, 3, "y1_restart");
      hold(2, 2, "ar1_restart");
      hold(3, 20, "g2_no_pend1");

      // Randomized traffic; timing changes only while held in reset.
      for (int s = 0; s < 4; s++) begin
         rst_n = 1'b0;
         model_reset();
         req1  = 1'b0;
         req2  = 1'b0;
         min_g = 16'($urandom_range(0, 6));
         max_g = 16'($urandom_range(0, 9));
         yel_t = 16'($urandom_range(0, 4));
         clr_t = 16'($urandom_range(0, 3));
         step();
         rst_n = 1'b1;
         for (int c = 0; c < 400; c++) begin
            apply_stimulus(5 + s * 25, 80 - s * 20);
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
